// File: rtl/ram_pkg.sv
// Shared types for the SPI-slave RAM stream checker: command decode,
// error classification and checker FSM states.
package ram_pkg;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISMATCH = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_PROTO    = 2'd3
   } err_code_e;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_TX = 1'b1
   } chk_state_e;

endpackage

// File: rtl/ram_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module ram_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/ram_stream_checker.sv
// Snoops the RAM command stream, mirrors writes into a shadow memory and
// scores each read response as correct, mismatched, timed out or skipped.
module ram_stream_checker
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int CNT_WIDTH  = 16,
   parameter int TX_TIMEOUT = 4,
   parameter int NUM_READS  = 100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [DATA_WIDTH+1:0] din,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-1:0] dout,
   output logic [CNT_WIDTH-1:0]  correct_count,
   output logic [CNT_WIDTH-1:0]  error_count,
   output logic [CNT_WIDTH-1:0]  skip_count,
   output logic                  err_flag,
   output logic [1:0]            last_err_code,
   output logic [ADDR_WIDTH-1:0] last_err_addr,
   output logic                  done
);

   localparam int TW = $clog2(TX_TIMEOUT + 1);
   localparam int SW = CNT_WIDTH + 2;

   cmd_e                  cmd;
   logic [ADDR_WIDTH-1:0] pl_addr;
   logic                  rd_cmd, wr_cmd;

   assign cmd     = cmd_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
   assign pl_addr = din[ADDR_WIDTH-1:0];
   assign rd_cmd  = rx_valid && (cmd == CMD_RD_DATA);
   assign wr_cmd  = rx_valid && (cmd == CMD_WR_DATA);

   chk_state_e            state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, exp_addr_q, exp_addr_d;
   logic [MEM_DEPTH-1:0]  valid_q, valid_d;
   logic                  err_flag_q, err_flag_d, done_q, done_d;
   err_code_e             last_err_code_q, last_err_code_d;
   logic [ADDR_WIDTH-1:0] last_err_addr_q, last_err_addr_d;
   logic [DATA_WIDTH-1:0] shadow_mem [MEM_DEPTH];

   logic                  inc_correct, inc_skip, err_ev;
   err_code_e             err_code;
   logic [ADDR_WIDTH-1:0] err_addr;
   logic                  bump;
   logic [SW-1:0]         sum_next;

   always_comb begin
      state_d         = state_q;
      timer_d         = timer_q;
      wr_addr_d       = wr_addr_q;
      rd_addr_d       = rd_addr_q;
      exp_addr_d      = exp_addr_q;
      valid_d         = valid_q;
      err_flag_d      = err_flag_q;
      last_err_code_d = last_err_code_q;
      last_err_addr_d = last_err_addr_q;
      inc_correct     = 1'b0;
      inc_skip        = 1'b0;
      err_ev          = 1'b0;
      err_code        = ERR_NONE;
      err_addr        = exp_addr_q;

      // Response scoring uses pre-cycle state, so a same-cycle write or
      // new read command cannot influence the check in flight.
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               err_ev   = 1'b1;
               err_code = ERR_PROTO;
               err_addr = rd_addr_q;
            end
         end
         WAIT_TX: begin
            if (tx_valid) begin
               state_d = IDLE;
               if (!valid_q[exp_addr_q])                 inc_skip    = 1'b1;
               else if (dout == shadow_mem[exp_addr_q])  inc_correct = 1'b1;
               else begin
                  err_ev   = 1'b1;
                  err_code = ERR_MISMATCH;
               end
            end else if (rd_cmd) begin
               err_ev   = 1'b1;
               err_code = ERR_PROTO;
            end else begin
               timer_d = timer_q + TW'(1);
               if (timer_d == TW'(TX_TIMEOUT)) begin
                  err_ev   = 1'b1;
                  err_code = ERR_TIMEOUT;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_cmd) begin
         state_d    = WAIT_TX;
         timer_d    = '0;
         exp_addr_d = rd_addr_q;
      end
      if (rx_valid && cmd == CMD_WR_ADDR) wr_addr_d = pl_addr;
      if (rx_valid && cmd == CMD_RD_ADDR) rd_addr_d = pl_addr;
      if (wr_cmd)                         valid_d[wr_addr_q] = 1'b1;

      if (err_ev) begin
         err_flag_d      = 1'b1;
         last_err_code_d = err_code;
         last_err_addr_d = err_addr;
      end

      // At most one counter moves per cycle, so one saturation-aware bump
      // gives the post-update total in the same cycle the counter changes.
      bump = (inc_correct && (correct_count != {CNT_WIDTH{1'b1}})) ||
             (inc_skip    && (skip_count    != {CNT_WIDTH{1'b1}})) ||
             (err_ev      && (error_count   != {CNT_WIDTH{1'b1}}));
      sum_next = SW'(correct_count) + SW'(error_count) + SW'(skip_count) + SW'(bump);
      done_d   = done_q || (32'(sum_next) >= NUM_READS);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         timer_q         <= '0;
         wr_addr_q       <= '0;
         rd_addr_q       <= '0;
         exp_addr_q      <= '0;
         valid_q         <= '0;
         err_flag_q      <= 1'b0;
         last_err_code_q <= ERR_NONE;
         last_err_addr_q <= '0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         wr_addr_q       <= wr_addr_d;
         rd_addr_q       <= rd_addr_d;
         exp_addr_q      <= exp_addr_d;
         valid_q         <= valid_d;
         err_flag_q      <= err_flag_d;
         last_err_code_q <= last_err_code_d;
         last_err_addr_q <= last_err_addr_d;
         done_q          <= done_d;
      end
   end

   // Data array is deliberately not reset; the valid bits gate its use.
   always_ff @(posedge clk) begin
      if (rst_n && wr_cmd) shadow_mem[wr_addr_q] <= din[DATA_WIDTH-1:0];
   end

   ram_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_correct (
      .clk(clk), .rst_n(rst_n), .inc(inc_correct), .count(correct_count));
   ram_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_error (
      .clk(clk), .rst_n(rst_n), .inc(err_ev), .count(error_count));
   ram_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_skip (
      .clk(clk), .rst_n(rst_n), .inc(inc_skip), .count(skip_count));

   assign err_flag      = err_flag_q;
   assign last_err_code = last_err_code_q;
   assign last_err_addr = last_err_addr_q;
   assign done          = done_q;

endmodule

// File: tb/tb_ram_stream_checker.sv
// Random and directed stimulus for two checker instances (16-bit and 4-bit
// counters) scored every cycle against a transaction-level model.
module tb_ram_stream_checker;

   localparam int DW  = 8;
   localparam int AW  = 8;
   localparam int TXT = 4;
   localparam int NR  = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_valid = 1'b0;
   logic [DW+1:0] din = '0;
   logic          tx_valid = 1'b0;
   logic [DW-1:0] dout = '0;

   logic [15:0]   a_cor, a_err, a_skp;
   logic          a_flag, a_done;
   logic [1:0]    a_code;
   logic [AW-1:0] a_addr;
   logic [3:0]    b_cor, b_err, b_skp;
   logic          b_flag, b_done;
   logic [1:0]    b_code;
   logic [AW-1:0] b_addr;

   always #5 clk = ~clk;

   ram_stream_checker #(.CNT_WIDTH(16), .TX_TIMEOUT(TXT), .NUM_READS(NR)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .tx_valid(tx_valid),
      .dout(dout), .correct_count(a_cor), .error_count(a_err), .skip_count(a_skp),
      .err_flag(a_flag), .last_err_code(a_code), .last_err_addr(a_addr), .done(a_done));

   ram_stream_checker #(.CNT_WIDTH(4), .TX_TIMEOUT(TXT), .NUM_READS(NR)) dut4 (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .tx_valid(tx_valid),
      .dout(dout), .correct_count(b_cor), .error_count(b_err), .skip_count(b_skp),
      .err_flag(b_flag), .last_err_code(b_code), .last_err_addr(b_addr), .done(b_done));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model: memory contents plus one outstanding read
   // with an absolute deadline, scored in arrival order.
   logic [DW-1:0] m_mem [256];
   bit            m_vld [256];
   logic [AW-1:0] m_waddr, m_raddr, m_exp, m_eaddr;
   bit            m_pend, m_flag, m_done_a, m_done_b;
   int            m_deadline, m_cyc, m_cor, m_erc, m_skp, m_code;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic m_error(input int code, input logic [AW-1:0] addr);
      m_erc++;
      m_flag  = 1'b1;
      m_code  = code;
      m_eaddr = addr;
   endtask

   task automatic m_reset();
      foreach (m_vld[i]) m_vld[i] = 1'b0;
      m_waddr = '0; m_raddr = '0; m_exp = '0; m_eaddr = '0;
      m_pend = 1'b0; m_flag = 1'b0; m_done_a = 1'b0; m_done_b = 1'b0;
      m_cor = 0; m_erc = 0; m_skp = 0; m_code = 0;
   endtask

   task automatic m_step(input bit rv, input bit rxv, input logic [DW+1:0] d,
                         input bit txv, input logic [DW-1:0] dq);
      logic [1:0]    c;
      logic [DW-1:0] pl;
      c  = d[DW+1:DW];
      pl = d[DW-1:0];
      if (!rv) m_reset();
      else begin
         if (txv) begin
            if (m_pend) begin
               if (!m_vld[m_exp])          m_skp++;
               else if (m_mem[m_exp] == dq) m_cor++;
               else                         m_error(1, m_exp);
               m_pend = 1'b0;
            end else m_error(3, m_raddr);
         end else if (m_pend && rxv && c == 2'b11) m_error(3, m_exp);
         else if (m_pend && m_cyc == m_deadline) begin
            m_error(2, m_exp);
            m_pend = 1'b0;
         end
         if (rxv) begin
            case (c)
               2'b00: m_waddr = pl;
               2'b01: begin m_mem[m_waddr] = pl; m_vld[m_waddr] = 1'b1; end
               2'b10: m_raddr = pl;
               default: begin m_pend = 1'b1; m_exp = m_raddr; m_deadline = m_cyc + TXT; end
            endcase
         end
         if (sat(m_cor, 65535) + sat(m_erc, 65535) + sat(m_skp, 65535) >= NR) m_done_a = 1'b1;
         if (sat(m_cor, 15) + sat(m_erc, 15) + sat(m_skp, 15) >= NR)          m_done_b = 1'b1;
      end
      m_cyc++;
   endtask

   task automatic check_all();
      chk("a_correct", a_cor, sat(m_cor, 65535));
      chk("a_error",   a_err, sat(m_erc, 65535));
      chk("a_skip",    a_skp, sat(m_skp, 65535));
      chk("a_flag",    a_flag, m_flag);
      chk("a_code",    a_code, m_code);
      chk("a_addr",    a_addr, m_eaddr);
      chk("a_done",    a_done, m_done_a);
      chk("b_correct", b_cor, sat(m_cor, 15));
      chk("b_error",   b_err, sat(m_erc, 15));
      chk("b_skip",    b_skp, sat(m_skp, 15));
      chk("b_flag",    b_flag, m_flag);
      chk("b_code",    b_code, m_code);
      chk("b_done",    b_done, m_done_b);
   endtask

   task automatic cycle(input bit rv, input bit rxv, input logic [DW+1:0] d,
                        input bit txv, input logic [DW-1:0] dq);
      rst_n = rv; rx_valid = rxv; din = d; tx_valid = txv; dout = dq;
      @(posedge clk);
      m_step(rv, rxv, d, txv, dq);
      @(negedge clk);
      check_all();
   endtask

   task automatic cmd(input logic [1:0] c, input logic [DW-1:0] pl);
      cycle(1'b1, 1'b1, {c, pl}, 1'b0, '0);
   endtask
   task automatic idle();
      cycle(1'b1, 1'b0, {2'b11, 8'hFF}, 1'b0, 8'h33);
   endtask
   task automatic tx(input logic [DW-1:0] dq);
      cycle(1'b1, 1'b0, '0, 1'b1, dq);
   endtask
   task automatic rst();
      cycle(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      m_cyc = 0;
      m_deadline = 0;
      m_reset();
      @(negedge clk);
      rst(); rst();
      chk("reset_correct", a_cor, 0);
      chk("reset_done", a_done, 0);

      // matched read
      cmd(2'b00, 8'h05); cmd(2'b01, 8'hA5); cmd(2'b10, 8'h05); cmd(2'b11, 8'h00); tx(8'hA5);
      chk("match_cnt", a_cor, 1);
      chk("match_flag", a_flag, 0);

      // mismatched read of the same word
      cmd(2'b11, 8'h00); tx(8'h5A);
      chk("mism_err", a_err, 1);
      chk("mism_code", a_code, 1);
      chk("mism_addr", a_addr, 8'h05);

      // timeout: quiet for TX_TIMEOUT-1 cycles, then the error lands
      rst();
      cmd(2'b11, 8'h00);
      for (int i = 0; i < TXT - 1; i++) idle();
      chk("tmo_early", a_err, 0);
      idle();
      chk("tmo_err", a_err, 1);
      chk("tmo_code", a_code, 2);
      tx(8'h00);
      chk("tmo_idle_tx", a_code, 3);

      // unwritten address is skipped
      rst();
      cmd(2'b10, 8'h10); cmd(2'b11, 8'h00); tx(8'h77);
      chk("skip_cnt", a_skp, 1);
      chk("skip_err", a_err, 0);

      // unexpected tx in IDLE then overlapping read
      rst();
      tx(8'h01); cmd(2'b11, 8'h00); cmd(2'b11, 8'h00);
      chk("proto_err", a_err, 2);
      chk("proto_code", a_code, 3);
      tx(8'h00);

      // reset while waiting clears pending read and valid bits
      rst();
      cmd(2'b00, 8'h05); cmd(2'b01, 8'hA5); cmd(2'b10, 8'h05); cmd(2'b11, 8'h00);
      rst();
      for (int i = 0; i < TXT + 2; i++) idle();
      chk("rstwait_err", a_err, 0);
      cmd(2'b10, 8'h05); cmd(2'b11, 8'h00); tx(8'hA5);
      chk("rstwait_skip", a_skp, 1);

      // NUM_READS matched reads: done rises with the last counter update
      rst();
      cmd(2'b00, 8'h05); cmd(2'b01, 8'hA5); cmd(2'b10, 8'h05);
      for (int i = 0; i < NR; i++) begin
         cmd(2'b11, 8'h00);
         chk("done_pre", a_done, 0);
         tx(8'hA5);
      end
      chk("done_set", a_done, 1);
      chk("sat4", b_cor, 15);
      cmd(2'b11, 8'h00); tx(8'hA5);
      chk("done_sticky", a_done, 1);

      // randomized traffic on a small address window
      rst();
      for (int i = 0; i < 3000; i++) begin
         bit            rv, rxv, txv;
         logic [1:0]    c;
         logic [DW-1:0] pl, dq;
         rv  = ($urandom_range(0, 299) != 0);
         rxv = ($urandom_range(0, 2) != 0);
         c   = 2'($urandom_range(0, 3));
         pl  = (c == 2'b01) ? 8'($urandom) : 8'($urandom_range(0, 15));
         txv = ($urandom_range(0, 3) == 0);
         dq  = ($urandom_range(0, 1) == 0) ? m_mem[m_exp] : 8'($urandom);
         if (dq === 'x) dq = 8'($urandom);
         cycle(rv, rxv, {c, pl}, txv, dq);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ram_stream_checker.md
Name: ram_stream_checker

Overview:
Synthesizable, parametrised protocol checker and scoreboard for the SPI-slave RAM command stream. It is the hardware successor to the simulation-only RAM monitor.
- Snoops rx_valid/din/tx_valid/dout.
- Keeps a shadow memory with per-word valid bits.
- Tracks read-response latency with a timeout and classifies errors.
- Drives saturating pass/error/skip counters and a done flag, usable in emulation or as a bench-side bound block.

Parameters:
DATA_WIDTH, 8, payload width of din and width of dout.
MEM_DEPTH, 256, shadow memory depth; must be a power of 2, at most 2**DATA_WIDTH.
ADDR_WIDTH, $clog2(MEM_DEPTH), derived; address taken from din payload LSBs.
CNT_WIDTH, 16, width of each statistics counter.
TX_TIMEOUT, 4, max cycles from read-data command to tx_valid; must be at least 1.
NUM_READS, 100, completed read checks that assert done.

Ports:
clk  in  1  single clock; all sampling on rising edge.
rst_n  in  1  reset, synchronous, active-low.
rx_valid  in  1  command/data valid from SPI side.
din  in  DATA_WIDTH+2  {cmd[1:0], payload}; cmd 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
tx_valid  in  1  RAM read-data valid.
dout  in  DATA_WIDTH  RAM read data.
correct_count  out  CNT_WIDTH  matched reads.
error_count  out  CNT_WIDTH  all errors (mismatch, timeout, unexpected tx, overlap).
skip_count  out  CNT_WIDTH  reads of never-written addresses (not compared).
err_flag  out  1  sticky; set on first error.
last_err_code  out  2  1 mismatch, 2 timeout, 3 unexpected tx/overlap; 0 none.
last_err_addr  out  ADDR_WIDTH  address of the most recent error.
done  out  1  sticky; set when correct+error+skip reads reach NUM_READS.

Behaviour:
- Reset (rst_n low at a rising edge): all outputs 0.
  - Internal wr_addr and rd_addr are 0; all valid bits cleared; FSM goes to IDLE.
  - Shadow data array is not cleared.
  - Reset mid-wait discards the pending read with no counter change.
- Command decode, only when rx_valid=1:
  - 00: wr_addr <= payload[ADDR_WIDTH-1:0].
  - 01: shadow[wr_addr] <= payload; valid[wr_addr] <= 1.
  - 10: rd_addr <= payload[ADDR_WIDTH-1:0].
  - 11: launches a read check; snapshot exp_addr <= rd_addr.
- FSM states IDLE and WAIT_TX, with a timer of width $clog2(TX_TIMEOUT+1).
- IDLE:
  - rd-data command -> WAIT_TX, timer=0.
  - tx_valid=1 -> error, code 3, addr=rd_addr.
- WAIT_TX:
  - Each cycle without tx_valid increments the timer.
  - Timer reaching TX_TIMEOUT with no tx_valid -> error, code 2, addr=exp_addr; go to IDLE.
  - tx_valid=1:
    - If valid[exp_addr]=0 -> skip_count++.
    - Else if dout==shadow[exp_addr] -> correct_count++.
    - Else error, code 1, addr=exp_addr.
    - Go to IDLE.
  - Another rd-data command while waiting, without tx_valid in the same cycle -> error, code 3. The old read is dropped and the wait restarts for the new read (timer=0).
- Same-cycle events:
  - tx_valid is evaluated against state and shadow contents from before this cycle's command.
  - A wr-data to exp_addr in the same cycle as tx_valid does not affect the comparison.
  - tx_valid plus a new rd-data in WAIT_TX: complete the old check, then re-enter WAIT_TX for the new one.
- Counters are registered and visible 1 cycle after the event. They saturate at all-ones. error_count increments once per error event.
- done asserts in the same cycle the completing counter updates. Checking continues after done.
- rx_valid=0: din is ignored. dout is ignored unless tx_valid=1.

Decomposition:
- ram_pkg holds:
  - cmd_e enum (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA).
  - err_code_e enum (ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT, ERR_PROTO).
  - chk_state_e enum (IDLE, WAIT_TX).
- One sub-module, ram_sat_counter: parametrised width, inc input, saturating. Instantiated three times.

Test Plan:
- Reset then wr-addr 0x05, wr-data 0xA5, rd-addr 0x05, rd-data; tx_valid=1 with dout=0xA5 one cycle later -> correct_count=1, err_flag=0.
- Same sequence with dout=0x5A -> error_count=1, last_err_code=1, last_err_addr=0x05, err_flag=1.
- rd-data, then no tx_valid for TX_TIMEOUT=4 cycles -> error_count=1, last_err_code=2 on cycle 5, FSM back in IDLE.
- Read address 0x10 never written, then tx_valid -> skip_count=1, correct_count=0, error_count=0.
- tx_valid in IDLE, then a second rd-data while waiting -> error_count=2, last_err_code=3.
- Assert rst_n=0 during WAIT_TX, then read address 0x05 -> no timeout error; read is skipped (valid bits cleared).
- Run NUM_READS=100 matched reads -> done=1 exactly on the counter update of the 100th read.
- With CNT_WIDTH=4, 20 matched reads -> correct_count holds at 15.
